// File: rtl/rv32_pkg.sv
// Shared state/owner encodings for the unified memory arbiter.
package rv32_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_GRANT_IF,
        ARB_GRANT_DM,
        ARB_RESP
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } arb_owner_t;

endpackage

// File: rtl/unified_mem_arbiter.sv
// Shares one single-ported memory between fetch and LSU with data-over-fetch priority.
// Define ARB_FAIRNESS_EN to force a fetch grant after MAX_DM_STREAK contended data grants.
module unified_mem_arbiter
    import rv32_pkg::*;
#(
    parameter int ADDR_W        = 32,
    parameter int DATA_W        = 32,
    parameter int MAX_DM_STREAK = 4
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                imem_ready,
    output logic [DATA_W-1:0]   imem_rdata,
    input  logic                dm_req,
    input  logic                dm_we,
    input  logic [ADDR_W-1:0]   dm_addr,
    input  logic [DATA_W-1:0]   dm_wdata,
    input  logic [DATA_W/8-1:0] dm_be,
    output logic                dmem_ready,
    output logic [DATA_W-1:0]   dmem_rdata,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic                mem_ack,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                arb_owner
);

    localparam int BE_W = DATA_W / 8;

    arb_state_t          state_q, state_d;
    arb_owner_t          owner_q;
    logic                grant_if, grant_dm, fetch_forced;
    logic                in_grant, owner_req, aborted_q;
    logic                mem_req_q, mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic [BE_W-1:0]     mem_be_q;
    logic [DATA_W-1:0]   imem_rdata_q, dmem_rdata_q;

`ifdef ARB_FAIRNESS_EN
    localparam int STREAK_W = $clog2(MAX_DM_STREAK + 1);
    logic [STREAK_W-1:0] streak_q, streak_d;

    assign fetch_forced = (streak_q == STREAK_W'(MAX_DM_STREAK));

    // Only data grants made while fetch is waiting count; an idle fetch side resets the streak.
    always_comb begin
        streak_d = streak_q;
        if (state_q == ARB_IDLE) begin
            if (!if_req || grant_if)
                streak_d = '0;
            else if (grant_dm && !fetch_forced)
                streak_d = streak_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) streak_q <= '0;
        else         streak_q <= streak_d;
    end
`else
    logic unused_streak_cfg;
    assign fetch_forced      = 1'b0;
    assign unused_streak_cfg = (MAX_DM_STREAK > 0);
`endif

    assign grant_if  = (state_q == ARB_IDLE) && if_req && (!dm_req || fetch_forced);
    assign grant_dm  = (state_q == ARB_IDLE) && dm_req && !grant_if;
    assign in_grant  = (state_q == ARB_GRANT_IF) || (state_q == ARB_GRANT_DM);
    assign owner_req = (owner_q == OWN_DM) ? dm_req : if_req;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= ARB_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_IDLE: begin
                if (grant_dm)      state_d = ARB_GRANT_DM;
                else if (grant_if) state_d = ARB_GRANT_IF;
            end
            ARB_GRANT_IF,
            ARB_GRANT_DM: if (mem_ack) state_d = ARB_RESP;
            ARB_RESP:     state_d = ARB_IDLE;
            default:      state_d = ARB_IDLE;
        endcase
    end

    // A requester that withdrew mid-transaction gets no completion pulse.
    always_comb begin
        imem_ready = ~if_req;
        dmem_ready = ~dm_req;
        if (state_q == ARB_RESP && !aborted_q) begin
            if (owner_q == OWN_IF) imem_ready = 1'b1;
            else                   dmem_ready = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            owner_q     <= OWN_IF;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
        end else if (grant_dm) begin
            owner_q     <= OWN_DM;
            mem_req_q   <= 1'b1;
            mem_we_q    <= dm_we;
            mem_addr_q  <= dm_addr;
            mem_wdata_q <= dm_wdata;
            mem_be_q    <= dm_we ? dm_be : '1;
        end else if (grant_if) begin
            owner_q     <= OWN_IF;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= if_addr;
            mem_wdata_q <= '0;
            mem_be_q    <= '1;
        end else if (in_grant && mem_ack) begin
            mem_req_q   <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)                    aborted_q <= 1'b0;
        else if (state_q == ARB_IDLE)   aborted_q <= 1'b0;
        else if (in_grant && !owner_req) aborted_q <= 1'b1;
    end

    // Stores leave the load data register untouched.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            imem_rdata_q <= '0;
            dmem_rdata_q <= '0;
        end else if (in_grant && mem_ack) begin
            if (owner_q == OWN_IF) imem_rdata_q <= mem_rdata;
            else if (!mem_we_q)    dmem_rdata_q <= mem_rdata;
        end
    end

    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_be     = mem_be_q;
    assign imem_rdata = imem_rdata_q;
    assign dmem_rdata = dmem_rdata_q;
    assign arb_owner  = owner_q;

endmodule
